// File: rtl/fib_arb_pkg.sv
// Shared types for the Fibonacci engine arbiter: sequencer states and id-width helper.
package fib_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    // Width of a requester index; never below one bit so a 2-port build still has a register.
    function automatic int unsigned id_width(input int unsigned n_req);
        return (n_req > 2) ? $clog2(n_req) : 1;
    endfunction

    localparam int unsigned NReqDefault = 4;
    localparam int unsigned IdWidth     = id_width(NReqDefault);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above ptr, else the lowest set one.
module rr_arbiter
    import fib_arb_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IdW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IdW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IdW-1:0] gnt_idx,
    output logic           any_gnt
);

    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        // Descending scans leave the lowest match; the at-or-above-ptr scan overrides the wrap.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_gnt = 1'b1;
                gnt_idx = IdW'(i);
            end
        end
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                gnt_idx = IdW'(i);
            end
        end
        gnt = any_gnt ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/fib_engine_arbiter.sv
// Round-robin sequencer sharing one multi-cycle Fibonacci engine between N_REQ requesters.
// Optional cycle/job counters are built only when FIB_ENGINE_ARBITER_PERF_EN is defined.
module fib_engine_arbiter
    import fib_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_count,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    eng_start,
    output logic [DATA_W-1:0]       eng_count,
    input  logic                    eng_done,
    input  logic [DATA_W-1:0]       eng_result,
    output logic [31:0]             perf_busy_cycles,
    output logic [31:0]             perf_jobs
);

    localparam int unsigned IdW = id_width(N_REQ);

    arb_state_e        state_q, state_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [IdW-1:0]    id_q, id_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [N_REQ-1:0]  gnt;
    logic [IdW-1:0]    gnt_idx;
    logic              any_gnt;
    logic              rsp_hs;

    rr_arbiter #(
        .N   (N_REQ),
        .IdW (IdW)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign rsp_hs    = (state_q == StResp) && rsp_ready[id_q];
    assign eng_count = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            id_q     <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        count_d  = count_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (any_gnt) begin
                    state_d = StIssue;
                    id_d    = gnt_idx;
                    count_d = req_count[32'(gnt_idx) * DATA_W +: DATA_W];
                    ptr_d   = (32'(gnt_idx) == N_REQ - 1) ? '0 : IdW'(gnt_idx + 1'b1);
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (eng_done) begin
                    result_d = eng_result;
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (rsp_hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        eng_start = 1'b0;
        unique case (state_q)
            StIdle:  req_ready = gnt;
            StIssue: eng_start = 1'b1;
            StResp: begin
                rsp_valid = N_REQ'(1) << id_q;
                rsp_data  = result_q;
            end
            default: ;
        endcase
    end

`ifdef FIB_ENGINE_ARBITER_PERF_EN
    logic [31:0] busy_q, jobs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            jobs_q <= '0;
        end else begin
            if (state_q != StIdle) begin
                busy_q <= busy_q + 32'd1;
            end
            if (rsp_hs) begin
                jobs_q <= jobs_q + 32'd1;
            end
        end
    end

    assign perf_busy_cycles = busy_q;
    assign perf_jobs        = jobs_q;
`else
    assign perf_busy_cycles = '0;
    assign perf_jobs        = '0;
`endif

endmodule

// File: tb/tb_fib_engine_arbiter.sv
// Bench for fib_engine_arbiter: engine model returns fib(count+1) three cycles after start.
module tb_fib_engine_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic         clk        = 1'b0;
    logic         reset_n    = 1'b0;
    logic [N-1:0] req_valid  = '0;
    logic [N-1:0] req_ready;
    logic [N*W-1:0] req_count = '0;
    logic [N-1:0] rsp_valid;
    logic [N-1:0] rsp_ready  = '0;
    logic [W-1:0] rsp_data;
    logic         eng_start;
    logic [W-1:0] eng_count;
    logic         eng_done   = 1'b0;
    logic [W-1:0] eng_result = '0;
    logic [31:0]  perf_busy_cycles;
    logic [31:0]  perf_jobs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_engine_arbiter #(
        .N_REQ  (N),
        .DATA_W (W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_count        (req_count),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .eng_start        (eng_start),
        .eng_count        (eng_count),
        .eng_done         (eng_done),
        .eng_result       (eng_result),
        .perf_busy_cycles (perf_busy_cycles),
        .perf_jobs        (perf_jobs)
    );

    function automatic logic [W-1:0] fib(input int unsigned n_in);
        logic [W-1:0] a, b, t;
        int unsigned n;
        n = (n_in > 64) ? 64 : n_in;
        a = '0;
        b = 1;
        for (int unsigned k = 0; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine model: not reset by reset_n, so an abandoned job still pulses done later.
    int           eng_left = 0;
    logic [W-1:0] eng_latched = '0;
    always @(posedge clk) begin
        eng_done   <= 1'b0;
        eng_result <= $urandom;
        if (eng_start) begin
            eng_left    <= 2;
            eng_latched <= eng_count;
        end else if (eng_left == 1) begin
            eng_left   <= 0;
            eng_done   <= 1'b1;
            eng_result <= fib(eng_latched + 1);
        end else if (eng_left > 1) begin
            eng_left <= eng_left - 1;
        end
    end

    // Reference model of arbitration and job flow.
    int           m_ptr = 0;
    bit           m_job = 0;
    int           m_id = 0;
    logic [W-1:0] m_count = '0;
    bit           m_start_due = 0;
    bit           m_done_seen = 0;
    bit           pend [N];
    logic [W-1:0] pend_cnt [N];
    logic [N-1:0] grant_q [$];
    logic [N-1:0] done_q [$];
    logic [W-1:0] res_q [$];

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_ptr = 0;
        m_job = 0;
        m_count = '0;
        m_start_due = 0;
        m_done_seen = 0;
        foreach (pend[i]) pend[i] = 0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_count = '0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        model_clear();
    endtask

    task automatic run_traffic(input int max_cycles, input int rsp_pct, input int new_pct,
                               input int budget, input int drop_pct);
        int cyc, g;
        bit any_pend, exp_start;
        logic [N-1:0] exp_ready, exp_rsp;
        logic [W-1:0] exp_data;
        cyc = 0;
        while (1) begin
            any_pend = 0;
            foreach (pend[i]) if (pend[i]) any_pend = 1;
            if (!any_pend && !m_job && budget == 0) break;
            if (cyc >= max_cycles) begin
                checks++;
                errors++;
                $display("FAIL traffic_timeout: %0d cycles used, limit %0d", cyc, max_cycles);
                break;
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && budget > 0 && $urandom_range(0, 99) < new_pct) begin
                    pend[i] = 1;
                    pend_cnt[i] = $urandom_range(0, 30);
                    budget--;
                end else if (pend[i] && $urandom_range(0, 99) < drop_pct) begin
                    pend[i] = 0;
                end
                req_valid[i] = pend[i];
                req_count[i*W +: W] = pend_cnt[i];
                rsp_ready[i] = ($urandom_range(0, 99) < rsp_pct);
            end
            @(negedge clk);
            exp_ready = '0;
            g = -1;
            if (!m_job) begin
                g = pick();
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            exp_start = m_start_due;
            exp_rsp = '0;
            exp_data = '0;
            if (m_job && m_done_seen) begin
                exp_rsp[m_id] = 1'b1;
                exp_data = fib(m_count + 1);
            end
            checks += 4;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL req_ready cyc %0d: got %b want %b", cyc, req_ready, exp_ready);
            end
            if (eng_start !== exp_start) begin
                errors++;
                $display("FAIL eng_start cyc %0d: got %b want %b", cyc, eng_start, exp_start);
            end
            if (rsp_valid !== exp_rsp || rsp_data !== exp_data) begin
                errors++;
                $display("FAIL rsp cyc %0d: got %b/%0d want %b/%0d", cyc, rsp_valid, rsp_data,
                         exp_rsp, exp_data);
            end
            if (eng_count !== m_count) begin
                errors++;
                $display("FAIL eng_count cyc %0d: got %0d want %0d", cyc, eng_count, m_count);
            end
            if (g >= 0) begin
                m_job = 1;
                m_id = g;
                m_count = pend_cnt[g];
                m_start_due = 1;
                m_done_seen = 0;
                m_ptr = (g + 1) % N;
                pend[g] = 0;
                grant_q.push_back(req_ready);
            end else if (m_start_due) begin
                m_start_due = 0;
            end else if (m_job && !m_done_seen) begin
                if (eng_done) m_done_seen = 1;
            end else if (m_job && rsp_ready[m_id]) begin
                m_job = 0;
                done_q.push_back(rsp_valid);
                res_q.push_back(rsp_data);
            end
            step();
            cyc++;
        end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_data, eng_start, eng_count, perf_busy_cycles, perf_jobs}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy %b vld %b data %0d start %b cnt %0d", req_ready,
                     rsp_valid, rsp_data, eng_start, eng_count);
        end
        step();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_data, eng_start, eng_count} !== '0) begin
            errors++;
            $display("FAIL after_release: got rdy %b vld %b start %b", req_ready, rsp_valid,
                     eng_start);
        end
        step();
        model_clear();
    endtask

    // Single job on port 0, count 10; response accepted one cycle late.
    task automatic test_single();
        int n;
        req_valid = 4'b0001;
        req_count[0 +: W] = 32'd10;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (eng_start !== 1'b1 || eng_count !== 32'd10 || req_ready !== '0) begin
            errors++;
            $display("FAIL single_issue: start %b cnt %0d rdy %b want 1/10/0000", eng_start,
                     eng_count, req_ready);
        end
        n = 0;
        while (rsp_valid === '0 && n < 12) begin
            step();
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 4 || rsp_valid !== 4'b0001 || rsp_data !== 32'd89) begin
            errors++;
            $display("FAIL single_rsp: after %0d cycles vld %b data %0d want 4/0001/89", n,
                     rsp_valid, rsp_data);
        end
        step();
        rsp_ready = 4'b0001;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 32'd89) begin
            errors++;
            $display("FAIL single_hold: vld %b data %0d want 0001/89", rsp_valid, rsp_data);
        end
        step();
        rsp_ready = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== '0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL single_release: vld %b data %0d want 0000/0", rsp_valid, rsp_data);
        end
        checks++;
`ifdef FIB_ENGINE_ARBITER_PERF_EN
        if (perf_jobs !== 32'd1 || perf_busy_cycles !== 32'd6) begin
            errors++;
            $display("FAIL perf: jobs %0d busy %0d want 1/6", perf_jobs, perf_busy_cycles);
        end
`else
        if (perf_jobs !== '0 || perf_busy_cycles !== '0) begin
            errors++;
            $display("FAIL perf_off: jobs %0d busy %0d want 0/0", perf_jobs, perf_busy_cycles);
        end
`endif
        step();
        m_ptr = 1;
        m_count = 32'd10;
    endtask

    task automatic test_all_four();
        logic [N-1:0] exp_g [4];
        logic [W-1:0] exp_r [4];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_r = '{32'd8, 32'd13, 32'd21, 32'd34};
        apply_reset();
        grant_q.delete();
        done_q.delete();
        res_q.delete();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1;
            pend_cnt[i] = 5 + i;
        end
        run_traffic(200, 100, 0, 0, 0);
        checks++;
        if (grant_q.size() != 4 || res_q.size() != 4) begin
            errors++;
            $display("FAIL all_four_count: grants %0d results %0d want 4/4", grant_q.size(),
                     res_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_q[i] !== exp_g[i] || done_q[i] !== exp_g[i] || res_q[i] !== exp_r[i])
                begin
                    errors++;
                    $display("FAIL all_four[%0d]: gnt %b rsp %b data %0d want %b/%0d", i,
                             grant_q[i], done_q[i], res_q[i], exp_g[i], exp_r[i]);
                end
            end
        end
    endtask

    task automatic test_rr_order();
        grant_q.delete();
        pend[2] = 1;
        pend_cnt[2] = $urandom_range(0, 30);
        run_traffic(100, 60, 0, 0, 0);
        pend[1] = 1;
        pend_cnt[1] = $urandom_range(0, 30);
        pend[3] = 1;
        pend_cnt[3] = $urandom_range(0, 30);
        run_traffic(200, 60, 0, 0, 0);
        checks++;
        if (grant_q.size() != 3 || grant_q[0] !== 4'b0100 || grant_q[1] !== 4'b1000 ||
            grant_q[2] !== 4'b0010) begin
            errors++;
            $display("FAIL rr_order: got %0d grants, first three %b %b %b want 0100 1000 0010",
                     grant_q.size(), grant_q[0], grant_q[1], grant_q[2]);
        end
    endtask

    // Response stalled with other ports requesting and asserting their own rsp_ready.
    task automatic test_resp_stall();
        int n;
        logic [W-1:0] c0, c2, c3;
        req_valid = 4'b0010;
        req_count[1*W +: W] = 32'd4;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL stall_grant: got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        n = 0;
        while (rsp_valid === '0 && n < 12) begin
            step();
            @(negedge clk);
            n++;
        end
        step();
        c0 = $urandom_range(0, 30);
        c2 = $urandom_range(0, 30);
        c3 = $urandom_range(0, 30);
        req_valid = 4'b1101;
        req_count = {c3, c2, 32'd0, c0};
        rsp_ready = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0010 || rsp_data !== 32'd5 || req_ready !== '0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: vld %b data %0d rdy %b want 0010/5/0000", k,
                         rsp_valid, rsp_data, req_ready);
            end
            step();
        end
        rsp_ready = 4'b0010;
        @(negedge clk);
        step();
        rsp_ready = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== '0 || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL stall_after: vld %b rdy %b want 0000/0100", rsp_valid, req_ready);
        end
        m_job = 1;
        m_id = 2;
        m_count = c2;
        m_start_due = 1;
        m_done_seen = 0;
        m_ptr = 3;
        pend[0] = 1;
        pend_cnt[0] = c0;
        pend[2] = 0;
        pend[3] = 1;
        pend_cnt[3] = c3;
        step();
        grant_q.delete();
        run_traffic(200, 50, 0, 0, 0);
        checks++;
        if (grant_q.size() != 2 || grant_q[0] !== 4'b1000 || grant_q[1] !== 4'b0001) begin
            errors++;
            $display("FAIL stall_followon: %0d grants, %b %b want 1000 0001", grant_q.size(),
                     grant_q[0], grant_q[1]);
        end
    endtask

    task automatic test_random();
        grant_q.delete();
        res_q.delete();
        run_traffic(4000, 50, 30, 60, 3);
        checks++;
        if (res_q.size() != grant_q.size() || grant_q.size() == 0) begin
            errors++;
            $display("FAIL random_jobs: %0d grants vs %0d responses", grant_q.size(),
                     res_q.size());
        end
    endtask

    // Reset mid-WAIT after a grant to port 2; the abandoned job's done lands in IDLE.
    task automatic test_reset_mid_wait();
        apply_reset();
        req_valid = 4'b0100;
        req_count[2*W +: W] = 32'd6;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL rmw_grant: got %b want 0100", req_ready);
        end
        step();
        req_valid = '0;
        step();
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_data, eng_start, eng_count, perf_busy_cycles, perf_jobs}
            !== '0) begin
            errors++;
            $display("FAIL rmw_in_reset: rdy %b vld %b start %b cnt %0d", req_ready, rsp_valid,
                     eng_start, eng_count);
        end
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, rsp_valid, rsp_data, eng_start, eng_count} !== '0) begin
                errors++;
                $display("FAIL rmw_idle[%0d]: rdy %b vld %b data %0d start %b done %b", k,
                         req_ready, rsp_valid, rsp_data, eng_start, eng_done);
            end
            step();
        end
        model_clear();
        grant_q.delete();
        pend[1] = 1;
        pend_cnt[1] = $urandom_range(0, 30);
        pend[3] = 1;
        pend_cnt[3] = $urandom_range(0, 30);
        run_traffic(200, 70, 0, 0, 0);
        checks++;
        if (grant_q.size() != 2 || grant_q[0] !== 4'b0010) begin
            errors++;
            $display("FAIL rmw_first_grant: %0d grants, first %b want 0010", grant_q.size(),
                     grant_q[0]);
        end
    endtask

    initial begin
        foreach (pend[i]) begin
            pend[i] = 0;
            pend_cnt[i] = '0;
        end
        test_reset();
        test_single();
        test_all_four();
        test_rr_order();
        test_resp_stall();
        test_random();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
